// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES-128 decryption sequencer and the memories
// it addresses.
//   state_e        : sequencer FSM states
//   NUM_ROUNDS     : AES-128 round count
//   KEY_EXP_CYCLES : cycles spent stepping key expansion (one per round key)
//   ROUND_W        : width of the round-key index / round counter
//   ADDR_W         : block address width, shared with the memories
package aes_seq_pkg;

  localparam int NUM_ROUNDS     = 10;
  localparam int KEY_EXP_CYCLES = 10;
  localparam int ROUND_W        = 4;
  localparam int ADDR_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_LOAD,
    ST_KEY_EXP,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/aes_dec_round_sequencer_if.sv
// Control/handshake bundle between the top-level start/finish logic, the
// round datapath and the sequencer.
//   master : start side and datapath side (drives start/count/ready)
//   slave  : the sequencer (drives address, enables and selects)
interface aes_dec_round_sequencer_if
  import aes_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W
);
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] num_blocks_i;
  logic                  out_ready_i;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  key_load_o;
  logic                  key_step_o;
  logic                  text_load_o;
  logic                  round_en_o;
  logic [ROUND_W-1:0]    round_o;
  logic                  mixcol_bypass_o;
  logic                  wr_en_o;
  logic                  busy_o;
  logic                  finish_o;

  modport master (
    output start_i, num_blocks_i, out_ready_i,
    input  pc_o, key_load_o, key_step_o, text_load_o, round_en_o, round_o,
           mixcol_bypass_o, wr_en_o, busy_o, finish_o
  );

  modport slave (
    input  start_i, num_blocks_i, out_ready_i,
    output pc_o, key_load_o, key_step_o, text_load_o, round_en_o, round_o,
           mixcol_bypass_o, wr_en_o, busy_o, finish_o
  );
endinterface

// File: rtl/aes_round_counter.sv
// Round counter used for both key expansion (counting up) and the inverse
// rounds (counting down).
//   clk, rst_n : clock, synchronous active-low reset (count -> 0)
//   load       : load load_value (wins over en)
//   load_value : value to load
//   en         : step the counter in the direction given by up
//   up         : 1 = count up, 0 = count down
//   count      : current value
//   tc         : terminal count for the current direction (UP_TC up, 1 down)
module aes_round_counter
  import aes_seq_pkg::*;
#(
  parameter logic [ROUND_W-1:0] UP_TC = ROUND_W'(KEY_EXP_CYCLES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [ROUND_W-1:0] load_value,
  input  logic               en,
  input  logic               up,
  output logic [ROUND_W-1:0] count,
  output logic               tc
);
  logic [ROUND_W-1:0] count_reg;
  logic [ROUND_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (en) begin
      count_next = up ? count_reg + 1'b1 : count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_reg <= '0;
    else        count_reg <= count_next;
  end

  assign count = count_reg;
  assign tc    = up ? (count_reg == UP_TC) : (count_reg == ROUND_W'(1));
endmodule

// File: rtl/aes_dec_round_sequencer.sv
// AES-128 decryption round sequencer. For each block of a run it loads the
// key, steps key expansion for rounds 1..NUM_ROUNDS, runs the initial
// AddRoundKey, inverse rounds NUM_ROUNDS-1..1 and the final round, then
// writes the plaintext under a ready handshake. pc_o addresses the block.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   bus (slave)   : start/num_blocks/out_ready in; pc, enables, round select,
//                   write strobe, busy and finish out
// All outputs are Moore decodes of the state and round counter registers.
module aes_dec_round_sequencer #(
  parameter int NUM_ROUNDS = aes_seq_pkg::NUM_ROUNDS,
  parameter int ADDR_WIDTH = aes_seq_pkg::ADDR_W
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  aes_dec_round_sequencer_if.slave bus
);
  import aes_seq_pkg::*;

  state_e                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0] count_reg, count_next;

  logic                  cnt_load, cnt_en, cnt_up, round_tc;
  logic [ROUND_W-1:0]    cnt_load_value, round_cnt;

  logic                  key_load, key_step, text_load, round_en;
  logic                  mixcol_bypass, wr_en, finish;
  logic [ROUND_W-1:0]    round_sel;

  aes_round_counter #(
    .UP_TC(ROUND_W'(NUM_ROUNDS))
  ) u_round_counter (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .load      (cnt_load),
    .load_value(cnt_load_value),
    .en        (cnt_en),
    .up        (cnt_up),
    .count     (round_cnt),
    .tc        (round_tc)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    count_next     = count_reg;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_en         = 1'b0;
    cnt_up         = 1'b1;
    key_load       = 1'b0;
    key_step       = 1'b0;
    text_load      = 1'b0;
    round_en       = 1'b0;
    mixcol_bypass  = 1'b0;
    wr_en          = 1'b0;
    finish         = 1'b0;
    round_sel      = '0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start_i) begin
          pc_next    = '0;
          count_next = bus.num_blocks_i;
          state_next = (bus.num_blocks_i == '0) ? ST_DONE : ST_KEY_LOAD;
        end
      end
      ST_KEY_LOAD: begin
        key_load       = 1'b1;
        cnt_load       = 1'b1;
        cnt_load_value = ROUND_W'(1);
        state_next     = ST_KEY_EXP;
      end
      ST_KEY_EXP: begin
        key_step  = 1'b1;
        round_sel = round_cnt;
        if (round_tc) state_next = ST_INIT;
        else          cnt_en     = 1'b1;
      end
      ST_INIT: begin
        // Initial AddRoundKey uses the last expanded key; the counter is
        // preloaded for the first inverse round.
        text_load      = 1'b1;
        round_sel      = ROUND_W'(NUM_ROUNDS);
        cnt_load       = 1'b1;
        cnt_load_value = ROUND_W'(NUM_ROUNDS - 1);
        state_next     = ST_ROUND;
      end
      ST_ROUND: begin
        round_en  = 1'b1;
        round_sel = round_cnt;
        cnt_up    = 1'b0;
        if (round_tc) state_next = ST_FINAL;
        else          cnt_en     = 1'b1;
      end
      ST_FINAL: begin
        round_en      = 1'b1;
        mixcol_bypass = 1'b1;
        state_next    = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        if (bus.out_ready_i) begin
          // count_reg is non-zero here, so count-1 cannot wrap.
          if (pc_reg == count_reg - 1'b1) begin
            state_next = ST_DONE;
          end else begin
            pc_next    = pc_reg + 1'b1;
            state_next = ST_KEY_LOAD;
          end
        end
      end
      ST_DONE: begin
        finish     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.pc_o            = pc_reg;
  assign bus.key_load_o      = key_load;
  assign bus.key_step_o      = key_step;
  assign bus.text_load_o     = text_load;
  assign bus.round_en_o      = round_en;
  assign bus.round_o         = round_sel;
  assign bus.mixcol_bypass_o = mixcol_bypass;
  assign bus.wr_en_o         = wr_en;
  assign bus.busy_o          = (state_reg != ST_IDLE);
  assign bus.finish_o        = finish;
endmodule

// File: tb/tb_aes_dec_round_sequencer.sv
// Bench for aes_dec_round_sequencer: a cycle-offset model of each block
// (phase 0 = key load ... phase 22+ = write) predicts every output on every
// cycle; directed runs add hand-computed literal expectations on top.
module tb_aes_dec_round_sequencer;
  logic clk;
  logic rst_n;

  aes_dec_round_sequencer_if #(.ADDR_WIDTH(8)) bus ();

  aes_dec_round_sequencer #(.NUM_ROUNDS(10), .ADDR_WIDTH(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_active = 1'b0;  // inside a block
  int m_phase  = 0;     // cycle offset inside the current block
  bit m_fin    = 1'b0;  // finish cycle
  int m_pc     = 0;
  int m_n      = 0;
  int m_rel    = 0;     // cycle number counted from the accepting edge

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_phase  <= 0;
      m_fin    <= 1'b0;
      m_pc     <= 0;
      m_n      <= 0;
      m_rel    <= 0;
    end else begin
      m_fin <= 1'b0;
      m_rel <= m_rel + 1;
      if (!m_active && !m_fin) begin
        if (bus.start_i) begin
          m_pc  <= 0;
          m_n   <= int'(bus.num_blocks_i);
          m_rel <= 1;
          if (bus.num_blocks_i == 0) m_fin <= 1'b1;
          else begin
            m_active <= 1'b1;
            m_phase  <= 0;
          end
        end
      end else if (m_active) begin
        if (m_phase >= 22) begin
          if (bus.out_ready_i) begin
            if (m_pc == m_n - 1) begin
              m_active <= 1'b0;
              m_fin    <= 1'b1;
            end else begin
              m_pc    <= m_pc + 1;
              m_phase <= 0;
            end
          end
        end else begin
          m_phase <= m_phase + 1;
        end
      end
    end
  end

  // {key_load, key_step, text_load, round_en, round[3:0], bypass, wr_en, busy, finish}
  function automatic logic [12:0] exp_vec(input bit act, input int ph, input bit fin);
    logic kl, ks, tl, re, byp, wr, busy, fn;
    logic [3:0] rnd;
    kl = 0; ks = 0; tl = 0; re = 0; byp = 0; wr = 0; busy = 0; fn = 0; rnd = 4'd0;
    if (act) begin
      busy = 1;
      if (ph == 0) kl = 1;
      else if (ph <= 10) begin ks = 1; rnd = 4'(ph); end
      else if (ph == 11) begin tl = 1; rnd = 4'd10; end
      else if (ph <= 20) begin re = 1; rnd = 4'(21 - ph); end
      else if (ph == 21) begin re = 1; byp = 1; end
      else wr = 1;
    end
    if (fin) begin busy = 1; fn = 1; end
    return {kl, ks, tl, re, rnd, byp, wr, busy, fn};
  endfunction

  int wr_cyc[$];
  int wr_pc[$];
  int fin_cyc[$];

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [12:0] act_v;
    act_v = {bus.key_load_o, bus.key_step_o, bus.text_load_o, bus.round_en_o, bus.round_o,
             bus.mixcol_bypass_o, bus.wr_en_o, bus.busy_o, bus.finish_o};
    chk("model_outputs", 32'(act_v), 32'(exp_vec(m_active, m_phase, m_fin)));
    chk("model_pc", 32'(bus.pc_o), 32'(m_pc));
    if (bus.wr_en_o === 1'b1 && bus.out_ready_i === 1'b1) begin
      wr_cyc.push_back(m_rel);
      wr_pc.push_back(int'(bus.pc_o));
      $display("write accepted: pc=%0d cycle=%0d", bus.pc_o, m_rel);
    end
    if (bus.finish_o === 1'b1) fin_cyc.push_back(m_rel);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_cyc.delete();
    wr_pc.delete();
    fin_cyc.delete();
  endtask

  // Returns at the negedge of cycle 1 (start accepted at the edge before it).
  task automatic start_run(input int n);
    bus.start_i      = 1'b1;
    bus.num_blocks_i = 8'(n);
    step(1);
    bus.start_i      = 1'b0;
    bus.num_blocks_i = 8'h55;
  endtask

  task automatic wait_finish(input int budget);
    int k;
    k = 0;
    while (bus.finish_o !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    chk("finish_within_budget", 32'(bus.finish_o), 32'd1);
    step(1);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.start_i      = 1'b0;
    bus.num_blocks_i = 8'd0;
    bus.out_ready_i  = 1'b1;
    step(3);
    // Reset state
    chk("reset_busy", 32'(bus.busy_o), 32'd0);
    chk("reset_pc", 32'(bus.pc_o), 32'd0);
    chk("reset_strobes", 32'({bus.key_load_o, bus.key_step_o, bus.text_load_o,
                              bus.round_en_o, bus.wr_en_o, bus.finish_o}), 32'd0);
    rst_n = 1'b1;
    step(1);

    // T1: single block, cycle-exact literals
    clear_logs();
    start_run(1);
    chk("t1_c1_key_load", 32'({bus.key_load_o, bus.busy_o}), 32'b11);
    step(1);
    for (int r = 1; r <= 10; r++) begin
      chk("t1_key_exp", 32'({bus.key_step_o, bus.round_o}), 32'({1'b1, 4'(r)}));
      step(1);
    end
    chk("t1_c12_init", 32'({bus.text_load_o, bus.round_o}), 32'h1a);
    step(1);
    for (int r = 9; r >= 1; r--) begin
      chk("t1_round", 32'({bus.round_en_o, bus.mixcol_bypass_o, bus.round_o}), 32'({2'b10, 4'(r)}));
      step(1);
    end
    chk("t1_c22_final", 32'({bus.round_en_o, bus.mixcol_bypass_o, bus.round_o}), 32'h30);
    step(1);
    chk("t1_c23_write", 32'({bus.wr_en_o, bus.pc_o}), 32'h100);
    step(1);
    chk("t1_c24_finish", 32'({bus.finish_o, bus.busy_o}), 32'b11);
    step(1);
    chk("t1_c25_idle", 32'({bus.finish_o, bus.busy_o}), 32'b00);

    // T2: three blocks, ready high
    clear_logs();
    start_run(3);
    wait_finish(200);
    chk("t2_num_writes", 32'(wr_cyc.size()), 32'd3);
    if (wr_cyc.size() == 3) begin
      chk("t2_w0_cycle", 32'(wr_cyc[0]), 32'd23);
      chk("t2_w1_cycle", 32'(wr_cyc[1]), 32'd46);
      chk("t2_w2_cycle", 32'(wr_cyc[2]), 32'd69);
      chk("t2_w0_pc", 32'(wr_pc[0]), 32'd0);
      chk("t2_w1_pc", 32'(wr_pc[1]), 32'd1);
      chk("t2_w2_pc", 32'(wr_pc[2]), 32'd2);
    end
    chk("t2_finish_cycle", 32'(fin_cyc.size() > 0 ? fin_cyc[0] : -1), 32'd70);

    // T3: back-pressure in cycles 23..27
    clear_logs();
    bus.out_ready_i = 1'b0;
    start_run(1);
    step(22);
    chk("t3_c23_wr_held", 32'({bus.wr_en_o, bus.pc_o}), 32'h100);
    step(4);
    chk("t3_c27_wr_held", 32'({bus.wr_en_o, bus.pc_o}), 32'h100);
    step(1);
    bus.out_ready_i = 1'b1;
    wait_finish(50);
    chk("t3_write_cycle", 32'(wr_cyc.size() > 0 ? wr_cyc[0] : -1), 32'd28);
    chk("t3_finish_cycle", 32'(fin_cyc.size() > 0 ? fin_cyc[0] : -1), 32'd29);

    // T4: zero-block run, then a start ignored mid-run
    clear_logs();
    start_run(0);
    chk("t4_c1_finish", 32'({bus.finish_o, bus.busy_o, bus.wr_en_o}), 32'b110);
    step(1);
    chk("t4_no_writes", 32'(wr_cyc.size()), 32'd0);
    clear_logs();
    start_run(2);
    step(9);
    bus.start_i      = 1'b1;
    bus.num_blocks_i = 8'd5;
    step(1);
    bus.start_i      = 1'b0;
    chk("t4_restart_ignored_pc", 32'(bus.pc_o), 32'd0);
    wait_finish(200);
    chk("t4_num_writes", 32'(wr_cyc.size()), 32'd2);
    chk("t4_last_write_cycle", 32'(wr_cyc.size() == 2 ? wr_cyc[1] : -1), 32'd46);
    chk("t4_finish_cycle", 32'(fin_cyc.size() > 0 ? fin_cyc[0] : -1), 32'd47);

    // T5: reset in cycle 15 of the second block aborts without a write
    clear_logs();
    start_run(2);
    step(37);
    rst_n = 1'b0;
    step(1);
    chk("t5_after_reset", 32'({bus.busy_o, bus.key_load_o, bus.key_step_o, bus.text_load_o,
                              bus.round_en_o, bus.round_o, bus.wr_en_o, bus.finish_o, bus.pc_o}), 32'd0);
    rst_n = 1'b1;
    chk("t5_writes_before_abort", 32'(wr_cyc.size()), 32'd1);
    step(1);
    clear_logs();
    start_run(1);
    wait_finish(50);
    chk("t5_fresh_write_cycle", 32'(wr_cyc.size() > 0 ? wr_cyc[0] : -1), 32'd23);
    chk("t5_fresh_write_pc", 32'(wr_pc.size() > 0 ? wr_pc[0] : -1), 32'd0);

    // T6: maximum block count, no address wrap
    clear_logs();
    start_run(255);
    wait_finish(7000);
    chk("t6_num_writes", 32'(wr_cyc.size()), 32'd255);
    chk("t6_last_pc", 32'(wr_pc.size() > 0 ? wr_pc[wr_pc.size() - 1] : -1), 32'd254);
    chk("t6_finish_cycle", 32'(fin_cyc.size() > 0 ? fin_cyc[0] : -1), 32'd5866);
    chk("t6_pc_hold", 32'(bus.pc_o), 32'd254);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
